// File: rtl/wtm8_iter_ctrl.sv
// Unsigned 8x8 multiplier sequencer: reuses one external 4x4 multiplier over four
// steps, shift-accumulating nibble partial products into a registered 16-bit product.
module wtm8_iter_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] P,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic [7:0]  op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  k, k_nxt;
  logic [15:0] acc, acc_nxt;
  logic [7:0]  ra, ra_nxt;
  logic [7:0]  rb, rb_nxt;
  logic [15:0] p_nxt;
  logic [7:0]  op_cnt_nxt;
  logic [15:0] term;
  logic [15:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= 2'd0;
      acc    <= 16'h0000;
      ra     <= 8'h00;
      rb     <= 8'h00;
      P      <= 16'h0000;
      op_cnt <= 8'h00;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      acc    <= acc_nxt;
      ra     <= ra_nxt;
      rb     <= rb_nxt;
      P      <= p_nxt;
      op_cnt <= op_cnt_nxt;
    end
  end

  // Weight of the current partial product: low*low, two cross terms, high*high.
  always_comb begin
    term = 16'h0000;
    case (k)
      2'd0:    term = {8'h00, mul_p};
      2'd1,
      2'd2:    term = {4'h0, mul_p, 4'h0};
      default: term = {mul_p, 8'h00};
    endcase
  end

  assign sum = acc + term;

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    acc_nxt    = acc;
    ra_nxt     = ra;
    rb_nxt     = rb;
    p_nxt      = P;
    op_cnt_nxt = op_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          ra_nxt  = a;
          rb_nxt  = b;
          acc_nxt = 16'h0000;
          k_nxt   = 2'd0;
          if ((a == 8'h00) || (b == 8'h00)) begin
            state_nxt = DONE;
            p_nxt     = 16'h0000;
          end else begin
            state_nxt = MUL;
          end
        end
      end
      MUL: begin
        acc_nxt = sum;
        k_nxt   = k + 2'd1;
        if (k == 2'd3) begin
          p_nxt     = sum;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt  = IDLE;
          op_cnt_nxt = op_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplier operands come only from registered state to keep input paths short.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    mul_a     = 4'h0;
    mul_b     = 4'h0;
    if (state == MUL) begin
      mul_a = k[0] ? ra[7:4] : ra[3:0];
      mul_b = k[1] ? rb[7:4] : rb[3:0];
    end
  end

endmodule
